// File: rtl/cpu_defs.sv
// cpu_defs: opcodes, ALU op codes and control-FSM state encodings for the multicycle core
package cpu_defs;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_FUNCT = 3'd7;
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC_R = 4'd2,
    EXEC_I = 4'd3,
    ADDR   = 4'd4,
    MEM_RD = 4'd5,
    MEM_WR = 4'd6,
    WB_R   = 4'd7,
    WB_I   = 4'd8,
    WB_LW  = 4'd9,
    BRANCH = 4'd10,
    JUMP   = 4'd11
  } state_t;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts memory wait cycles and flags the last allowed one
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic timeout
);
  localparam int CW = MEM_TIMEOUT > 2 ? $clog2(MEM_TIMEOUT) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  // a timeout also restarts the count, since FETCH re-enters itself without a state change
  always_comb begin
    timeout = en && cnt_q == CW'(MEM_TIMEOUT - 1);
    cnt_d = (en && !timeout) ? cnt_q + CW'(1) : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM sequencing the multicycle MIPS datapath
module multicycle_ctrl
  import cpu_defs::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_ce,
  output logic       ir_ce,
  output logic       mdr_ce,
  output logic       ab_ce,
  output logic       aluout_ce,
  output logic       reg_we,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       iord,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_src,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [3:0] state,
  output logic       illegal,
  output logic       mem_err
);
  state_t state_q, state_d;
  logic   wait_en, timeout, unused_funct;
  assign unused_funct = ^funct;
  assign state = state_q;
  assign wait_en = (state_q == FETCH || state_q == MEM_RD || state_q == MEM_WR) && !mem_ready;
  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .en      (wait_en),
    .timeout (timeout)
  );
  always_comb begin
    state_d = state_q;
    {pc_ce, ir_ce, mdr_ce, ab_ce, aluout_ce, reg_we, mem_rd, mem_wr, iord, alu_src_a} = 10'd0;
    alu_src_b = 2'd0;
    alu_op = ALU_ADD;
    pc_src = 2'd0;
    {reg_dst, mem_to_reg, illegal, mem_err} = 4'd0;
    case (state_q)
      FETCH: begin
        mem_rd = 1'b1;
        alu_src_b = 2'd1;
        pc_ce = mem_ready;
        ir_ce = mem_ready;
        mem_err = timeout;
        state_d = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ab_ce = 1'b1;
        aluout_ce = 1'b1;
        alu_src_b = 2'd3;
        state_d = opcode == OP_RTYPE ? EXEC_R :
                  (opcode == OP_LW || opcode == OP_SW) ? ADDR :
                  opcode == OP_ADDI ? EXEC_I :
                  opcode == OP_BEQ ? BRANCH :
                  opcode == OP_J ? JUMP : FETCH;
        illegal = state_d == FETCH;
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op = ALU_FUNCT;
        aluout_ce = 1'b1;
        state_d = WB_R;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        aluout_ce = 1'b1;
        state_d = WB_I;
      end
      ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        aluout_ce = 1'b1;
        state_d = opcode == OP_LW ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_rd = 1'b1;
        iord = 1'b1;
        mdr_ce = mem_ready;
        mem_err = timeout;
        state_d = mem_ready ? WB_LW : timeout ? FETCH : MEM_RD;
      end
      MEM_WR: begin
        mem_wr = 1'b1;
        iord = 1'b1;
        mem_err = timeout;
        state_d = (mem_ready || timeout) ? FETCH : MEM_WR;
      end
      WB_R: begin
        reg_we = 1'b1;
        reg_dst = 1'b1;
        state_d = FETCH;
      end
      WB_I: begin
        reg_we = 1'b1;
        state_d = FETCH;
      end
      WB_LW: begin
        reg_we = 1'b1;
        mem_to_reg = 1'b1;
        state_d = FETCH;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op = ALU_SUB;
        pc_src = 2'd1;
        pc_ce = zero;
        state_d = FETCH;
      end
      JUMP: begin
        pc_src = 2'd2;
        pc_ce = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    if (rst) begin
      {pc_ce, ir_ce, mdr_ce, ab_ce, aluout_ce, reg_we, mem_rd, mem_wr, iord, alu_src_a} = 10'd0;
      {alu_src_b, alu_op, pc_src, reg_dst, mem_to_reg, illegal, mem_err} = 11'd0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= FETCH;
    else state_q <= state_d;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table-driven per-cycle check of the multicycle control FSM
module tb_multicycle_ctrl;
  localparam logic [3:0] FE = 4'd0, DE = 4'd1, ER = 4'd2, EI = 4'd3, AD = 4'd4, MR = 4'd5;
  localparam logic [3:0] MW = 4'd6, WR = 4'd7, WI = 4'd8, WL = 4'd9, BR = 4'd10, JP = 4'd11;
  localparam logic [9:0] SF  = 10'b0_01_000_00_0_0;
  localparam logic [9:0] SD  = 10'b0_11_000_00_0_0;
  localparam logic [9:0] SER = 10'b1_00_111_00_0_0;
  localparam logic [9:0] SEI = 10'b1_10_000_00_0_0;
  localparam logic [9:0] SWR = 10'b0_00_000_00_1_0;
  localparam logic [9:0] SWL = 10'b0_00_000_00_0_1;
  localparam logic [9:0] SBR = 10'b1_00_001_01_0_0;
  localparam logic [9:0] SJ  = 10'b0_00_000_10_0_0;
  localparam logic [9:0] S0  = 10'b0;
  typedef struct {
    logic [5:0] op;
    logic       z;
    logic       rdy;
    logic [3:0] st;
    logic [5:0] ce;
    logic [2:0] mem;
    logic [9:0] sel;
    logic [1:0] flg;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [5:0] opcode = 6'd0, funct = 6'h20;
  logic zero = 1'b0, mem_ready = 1'b1;
  logic pc_ce, ir_ce, mdr_ce, ab_ce, aluout_ce, reg_we, mem_rd, mem_wr, iord, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_op;
  logic reg_dst, mem_to_reg, illegal, mem_err;
  logic [3:0] state;
  int checks = 0, errors = 0;
  vec_t tbl[$];
  always #5 clk = ~clk;
  multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_ce(pc_ce), .ir_ce(ir_ce), .mdr_ce(mdr_ce), .ab_ce(ab_ce), .aluout_ce(aluout_ce),
    .reg_we(reg_we), .mem_rd(mem_rd), .mem_wr(mem_wr), .iord(iord), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .state(state), .illegal(illegal), .mem_err(mem_err)
  );
  function automatic logic [24:0] outs();
    return {state, pc_ce, ir_ce, mdr_ce, ab_ce, aluout_ce, reg_we, mem_rd, mem_wr, iord,
            alu_src_a, alu_src_b, alu_op, pc_src, reg_dst, mem_to_reg, illegal, mem_err};
  endfunction
  task automatic chk(input string nm, input logic [24:0] act, input logic [24:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask
  task automatic add(input logic [5:0] op, input logic z, input logic rdy, input logic [3:0] st,
                     input logic [5:0] ce, input logic [2:0] mem, input logic [9:0] sel,
                     input logic [1:0] flg);
    vec_t v;
    v.op = op; v.z = z; v.rdy = rdy; v.st = st; v.ce = ce; v.mem = mem; v.sel = sel; v.flg = flg;
    tbl.push_back(v);
  endtask
  task automatic cyc(input vec_t v, input string nm);
    opcode = v.op;
    zero = v.z;
    mem_ready = v.rdy;
    #1;
    chk(nm, outs(), {v.st, v.ce, v.mem, v.sel, v.flg});
    @(negedge clk);
  endtask
  task automatic fetch_wait(input logic [5:0] op, input int n);
    for (int k = 0; k < n; k++) add(op, 0, 0, FE, 6'b000000, 3'b100, SF, 2'b00);
  endtask
  initial begin
    vec_t v;
    add(6'h00, 0, 1, FE, 6'b110000, 3'b100, SF, 2'b00);
    add(6'h00, 0, 1, DE, 6'b000110, 3'b000, SD, 2'b00);
    add(6'h00, 0, 1, ER, 6'b000010, 3'b000, SER, 2'b00);
    add(6'h00, 0, 1, WR, 6'b000001, 3'b000, SWR, 2'b00);
    add(6'h08, 0, 1, FE, 6'b110000, 3'b100, SF, 2'b00);
    add(6'h08, 0, 1, DE, 6'b000110, 3'b000, SD, 2'b00);
    add(6'h08, 0, 1, EI, 6'b000010, 3'b000, SEI, 2'b00);
    add(6'h08, 0, 1, WI, 6'b000001, 3'b000, S0, 2'b00);
    add(6'h2B, 0, 1, FE, 6'b110000, 3'b100, SF, 2'b00);
    add(6'h2B, 0, 1, DE, 6'b000110, 3'b000, SD, 2'b00);
    add(6'h2B, 0, 1, AD, 6'b000010, 3'b000, SEI, 2'b00);
    add(6'h2B, 0, 1, MW, 6'b000000, 3'b011, S0, 2'b00);
    add(6'h23, 0, 1, FE, 6'b110000, 3'b100, SF, 2'b00);
    add(6'h23, 0, 1, DE, 6'b000110, 3'b000, SD, 2'b00);
    add(6'h23, 0, 1, AD, 6'b000010, 3'b000, SEI, 2'b00);
    for (int k = 0; k < 3; k++) add(6'h23, 0, 0, MR, 6'b000000, 3'b101, S0, 2'b00);
    add(6'h23, 0, 1, MR, 6'b001000, 3'b101, S0, 2'b00);
    add(6'h23, 0, 1, WL, 6'b000001, 3'b000, SWL, 2'b00);
    add(6'h04, 1, 1, FE, 6'b110000, 3'b100, SF, 2'b00);
    add(6'h04, 1, 1, DE, 6'b000110, 3'b000, SD, 2'b00);
    add(6'h04, 1, 1, BR, 6'b100000, 3'b000, SBR, 2'b00);
    add(6'h04, 0, 1, FE, 6'b110000, 3'b100, SF, 2'b00);
    add(6'h04, 0, 1, DE, 6'b000110, 3'b000, SD, 2'b00);
    add(6'h04, 0, 1, BR, 6'b000000, 3'b000, SBR, 2'b00);
    add(6'h02, 0, 1, FE, 6'b110000, 3'b100, SF, 2'b00);
    add(6'h02, 0, 1, DE, 6'b000110, 3'b000, SD, 2'b00);
    add(6'h02, 0, 1, JP, 6'b100000, 3'b000, SJ, 2'b00);
    add(6'h3F, 0, 1, FE, 6'b110000, 3'b100, SF, 2'b00);
    add(6'h3F, 0, 1, DE, 6'b000110, 3'b000, SD, 2'b10);
    fetch_wait(6'h3F, 3);
    add(6'h3F, 0, 0, FE, 6'b000000, 3'b100, SF, 2'b01);
    fetch_wait(6'h02, 3);
    add(6'h02, 0, 1, FE, 6'b110000, 3'b100, SF, 2'b00);
    add(6'h02, 0, 1, DE, 6'b000110, 3'b000, SD, 2'b00);
    add(6'h02, 0, 1, JP, 6'b100000, 3'b000, SJ, 2'b00);
    add(6'h23, 0, 1, FE, 6'b110000, 3'b100, SF, 2'b00);
    add(6'h23, 0, 1, DE, 6'b000110, 3'b000, SD, 2'b00);
    add(6'h23, 0, 1, AD, 6'b000010, 3'b000, SEI, 2'b00);
    for (int k = 0; k < 3; k++) add(6'h23, 0, 0, MR, 6'b000000, 3'b101, S0, 2'b00);
    add(6'h23, 0, 0, MR, 6'b000000, 3'b101, S0, 2'b01);
    add(6'h00, 0, 1, FE, 6'b110000, 3'b100, SF, 2'b00);
    add(6'h00, 0, 1, DE, 6'b000110, 3'b000, SD, 2'b00);
    add(6'h00, 0, 1, ER, 6'b000010, 3'b000, SER, 2'b00);
    add(6'h00, 0, 1, WR, 6'b000001, 3'b000, SWR, 2'b00);
    repeat (2) @(negedge clk);
    #1 chk("reset_rdy1", outs(), 25'd0);
    mem_ready = 1'b0;
    opcode = 6'h3F;
    #1 chk("reset_rdy0", outs(), 25'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < tbl.size(); i++) cyc(tbl[i], $sformatf("vec%0d", i));
    add(6'h2B, 0, 1, FE, 6'b110000, 3'b100, SF, 2'b00);
    add(6'h2B, 0, 1, DE, 6'b000110, 3'b000, SD, 2'b00);
    add(6'h2B, 0, 1, AD, 6'b000010, 3'b000, SEI, 2'b00);
    add(6'h2B, 0, 0, MW, 6'b000000, 3'b011, S0, 2'b00);
    add(6'h2B, 0, 0, MW, 6'b000000, 3'b011, S0, 2'b00);
    for (int i = tbl.size() - 5; i < tbl.size(); i++) cyc(tbl[i], $sformatf("sw_wait%0d", i));
    mem_ready = 1'b0;
    #2 rst = 1'b1;
    #1 chk("rst_mid_memwr", outs(), 25'd0);
    @(negedge clk);
    rst = 1'b0;
    tbl.delete();
    fetch_wait(6'h00, 3);
    add(6'h00, 0, 0, FE, 6'b000000, 3'b100, SF, 2'b01);
    add(6'h00, 0, 1, FE, 6'b110000, 3'b100, SF, 2'b00);
    add(6'h00, 0, 1, DE, 6'b000110, 3'b000, SD, 2'b00);
    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      cyc(v, $sformatf("post_rst%0d", i));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
